// File: rtl/prog_mem_reader.sv
// ---------------------------------------------------------------------------
// prog_mem_reader
//   Readback engine for the CPU's program/data RAM. Once the CPU has halted,
//   a start pulse walks FIRST_ADDR..LAST_ADDR through a synchronous read
//   port. Each word goes out with its address on a valid/ready stream, and a
//   running checksum of the accepted words is kept.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   start      dump request, sampled only in IDLE
//   hlt        CPU halted; a dump runs only while it is high
//   rd_en      RAM read strobe (qualifies rd_addr)
//   rd_addr    RAM read address
//   rd_data    RAM read data, valid the cycle after rd_en
//   out_valid  out_addr/out_data/out_last valid
//   out_ready  consumer accepts the presented word
//   out_addr   address of the presented word
//   out_data   presented word
//   out_last   presented word is the one at LAST_ADDR
//   busy       FSM not in IDLE
//   done       one-cycle pulse after the last word is accepted
//   err        one-cycle pulse on a refused start or an abort
//   checksum   mod-2^DATA_W sum of accepted words
// ---------------------------------------------------------------------------
module prog_mem_reader #(
   parameter int ADDR_W     = 4,
   parameter int DATA_W     = 8,
   parameter int FIRST_ADDR = 0,
   parameter int LAST_ADDR  = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              hlt,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] checksum
);

   localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_ADDR);
   localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      PRESENT,
      DONE
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] ptr;

   // All outputs are registered. Each transition sets the outputs that belong
   // to the state being entered, so rd_en is high exactly in REQ, out_valid
   // exactly in PRESENT and done exactly in DONE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         ptr       <= FIRST_A;
         rd_en     <= 1'b0;
         rd_addr   <= '0;
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_data  <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         checksum  <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (hlt) begin
                     checksum <= '0;
                     ptr      <= FIRST_A;
                     rd_addr  <= FIRST_A;
                     rd_en    <= 1'b1;
                     busy     <= 1'b1;
                     state    <= REQ;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end

            REQ, WAIT, PRESENT: begin
               if (!hlt) begin
                  // Abort takes priority over a same-cycle handshake, so the
                  // pending word never reaches the checksum.
                  rd_en     <= 1'b0;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  err       <= 1'b1;
                  state     <= IDLE;
               end else if (state == REQ) begin
                  rd_en <= 1'b0;
                  state <= WAIT;
               end else if (state == WAIT) begin
                  out_data  <= rd_data;
                  out_addr  <= ptr;
                  out_last  <= (ptr == LAST_A);
                  out_valid <= 1'b1;
                  state     <= PRESENT;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  checksum  <= checksum + out_data;
                  if (out_last) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     ptr     <= ptr + 1'b1;
                     rd_addr <= ptr + 1'b1;
                     rd_en   <= 1'b1;
                     state   <= REQ;
                  end
               end
            end

            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               rd_en     <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_mem_reader.sv
// ---------------------------------------------------------------------------
// tb_prog_mem_reader
//   Directed bench for prog_mem_reader. Two instances: a full 0..15 dump and
//   a 9..10 window. Expected words are queued when a dump is launched; per-
//   instance monitors pop and compare on every accepted word.
// ---------------------------------------------------------------------------
module tb_prog_mem_reader;

   typedef struct packed {
      logic [3:0] a;
      logic [7:0] d;
      logic       l;
   } word_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] mem [16];

   // full-range instance
   logic       start = 1'b0, hlt = 1'b1, out_ready = 1'b1;
   logic       rd_en, out_valid, out_last, busy, done, err;
   logic [3:0] rd_addr, out_addr;
   logic [7:0] rd_data = '0, out_data, checksum;

   // windowed instance
   logic       start2 = 1'b0, hlt2 = 1'b1, out_ready2 = 1'b1;
   logic       rd_en2, out_valid2, out_last2, busy2, done2, err2;
   logic [3:0] rd_addr2, out_addr2;
   logic [7:0] rd_data2 = '0, out_data2, checksum2;

   int checks = 0, failures = 0;
   int done_cnt = 0, done_cnt2 = 0;
   word_t q1[$], q2[$];

   always #5 clk = ~clk;

   prog_mem_reader #(.ADDR_W(4), .DATA_W(8), .FIRST_ADDR(0), .LAST_ADDR(15)) dut (
      .clk(clk), .reset(reset), .start(start), .hlt(hlt),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
      .err(err), .checksum(checksum)
   );

   prog_mem_reader #(.ADDR_W(4), .DATA_W(8), .FIRST_ADDR(9), .LAST_ADDR(10)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .hlt(hlt2),
      .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_addr(out_addr2),
      .out_data(out_data2), .out_last(out_last2), .busy(busy2), .done(done2),
      .err(err2), .checksum(checksum2)
   );

   // synchronous-read RAM models
   always @(posedge clk) begin
      if (rd_en)  rd_data  <= mem[rd_addr];
      if (rd_en2) rd_data2 <= mem[rd_addr2];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // monitor: full-range instance
   logic  pend1 = 1'b0;
   word_t hold1;
   always @(negedge clk) begin
      word_t cur, e;
      cur = '{a: out_addr, d: out_data, l: out_last};
      if (done) done_cnt++;
      if (reset && out_valid) begin
         if (pend1) chk("dut1_hold_stable", 32'(cur), 32'(hold1));
         if (out_ready && hlt) begin
            if (q1.size() == 0) chk("dut1_unexpected_word", 32'(cur), 32'hFFFF_FFFF);
            else begin
               e = q1.pop_front();
               chk("dut1_word", 32'(cur), 32'(e));
            end
         end
      end
      pend1 = reset && out_valid && !(out_ready && hlt);
      hold1 = cur;
   end

   // monitor: windowed instance
   always @(negedge clk) begin
      word_t cur, e;
      cur = '{a: out_addr2, d: out_data2, l: out_last2};
      if (done2) done_cnt2++;
      if (reset && out_valid2 && out_ready2 && hlt2) begin
         if (q2.size() == 0) chk("dut2_unexpected_word", 32'(cur), 32'hFFFF_FFFF);
         else begin
            e = q2.pop_front();
            chk("dut2_word", 32'(cur), 32'(e));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_full();
      for (int i = 0; i < 16; i++)
         q1.push_back('{a: 4'(i), d: mem[i], l: (i == 15)});
   endtask

   // Wait for dut to drop busy; optionally toggle out_ready every cycle.
   task automatic wait_idle(input string name, input bit toggle);
      int n;
      n = 0;
      while (busy && n < 400) begin
         if (toggle) out_ready = ~out_ready;
         tick();
         n++;
      end
      out_ready = 1'b1;
      if (busy) chk(name, 32'(busy), 32'd0);
   endtask

   initial begin
      int n, d0;
      foreach (mem[i]) mem[i] = 8'h00;
      mem[0] = 8'h79; mem[1] = 8'h30; mem[2] = 8'h9A; mem[9] = 8'h03; mem[10] = 8'h05;

      // reset state
      #3;
      chk("rst_outputs", 32'({rd_en, rd_addr, out_valid, out_addr, out_data, out_last,
                              busy, done, err, checksum}), 32'd0);
      #10 reset = 1'b1;
      tick();

      // 1: full dump, ready held high, including 2-cycle start latency
      push_full();
      d0 = done_cnt;
      start = 1'b1; hlt = 1'b1; out_ready = 1'b1;
      tick(); start = 1'b0;
      chk("t1_req_rd_en", 32'(rd_en), 32'd1);
      chk("t1_req_rd_addr", 32'(rd_addr), 32'd0);
      chk("t1_busy", 32'(busy), 32'd1);
      tick();
      chk("t1_wait_valid", 32'({rd_en, out_valid}), 32'd0);
      tick();
      chk("t1_present_valid", 32'(out_valid), 32'd1);
      wait_idle("t1_timeout", 1'b0);
      chk("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
      chk("t1_queue_drained", 32'(q1.size()), 32'd0);
      chk("t1_checksum", 32'(checksum), 32'h4B);

      // 2: same dump with out_ready toggling
      push_full();
      d0 = done_cnt;
      start = 1'b1;
      tick(); start = 1'b0;
      wait_idle("t2_timeout", 1'b1);
      chk("t2_done_pulses", 32'(done_cnt - d0), 32'd1);
      chk("t2_queue_drained", 32'(q1.size()), 32'd0);
      chk("t2_checksum", 32'(checksum), 32'h4B);

      // 3: start refused while CPU running
      hlt = 1'b0; start = 1'b1;
      tick(); start = 1'b0;
      chk("t3_err_pulse", 32'(err), 32'd1);
      chk("t3_busy_rd_en", 32'({busy, rd_en}), 32'd0);
      tick();
      chk("t3_err_cleared", 32'({err, busy, rd_en}), 32'd0);
      chk("t3_checksum_kept", 32'(checksum), 32'h4B);

      // 4: abort while presenting address 5
      for (int i = 0; i < 5; i++) q1.push_back('{a: 4'(i), d: mem[i], l: 1'b0});
      d0 = done_cnt;
      hlt = 1'b1; start = 1'b1;
      tick(); start = 1'b0;
      n = 0;
      while (!(out_valid && out_addr == 4'd5) && n < 100) begin tick(); n++; end
      chk("t4_reached_addr5", 32'(out_valid && out_addr == 4'd5), 32'd1);
      hlt = 1'b0;
      tick();
      chk("t4_abort_err", 32'(err), 32'd1);
      chk("t4_abort_valid_busy", 32'({out_valid, busy}), 32'd0);
      chk("t4_partial_checksum", 32'(checksum), 32'h43);
      tick();
      chk("t4_err_cleared", 32'(err), 32'd0);
      chk("t4_no_done", 32'(done_cnt - d0), 32'd0);
      chk("t4_queue_drained", 32'(q1.size()), 32'd0);
      hlt = 1'b1;

      // 5: asynchronous reset in WAIT
      start = 1'b1;
      tick(); start = 1'b0;
      tick();
      chk("t5_in_wait", 32'({busy, rd_en, out_valid}), 32'b100);
      #2 reset = 1'b0;
      #1;
      chk("t5_async_reset", 32'({rd_en, rd_addr, out_valid, out_addr, out_data, out_last,
                                 busy, done, err, checksum}), 32'd0);
      #3 reset = 1'b1;
      tick();
      push_full();
      d0 = done_cnt;
      start = 1'b1;
      tick(); start = 1'b0;
      chk("t5_restart_addr", 32'(rd_addr), 32'd0);
      wait_idle("t5_timeout", 1'b0);
      chk("t5_done_pulses", 32'(done_cnt - d0), 32'd1);
      chk("t5_checksum", 32'(checksum), 32'h4B);

      // 6: windowed instance 9..10, second start mid-dump ignored
      q2.push_back('{a: 4'h9, d: 8'h03, l: 1'b0});
      q2.push_back('{a: 4'hA, d: 8'h05, l: 1'b1});
      start2 = 1'b1;
      tick(); start2 = 1'b0;
      chk("t6_first_addr", 32'({rd_en2, rd_addr2}), 32'h19);
      tick();
      start2 = 1'b1;
      tick(); start2 = 1'b0;
      chk("t6_restart_ignored", 32'({err2, busy2}), 32'b01);
      n = 0;
      while (busy2 && n < 100) begin tick(); n++; end
      chk("t6_idle", 32'(busy2), 32'd0);
      chk("t6_done_pulses", 32'(done_cnt2), 32'd1);
      chk("t6_queue_drained", 32'(q2.size()), 32'd0);
      chk("t6_checksum", 32'(checksum2), 32'h08);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
